// File: rtl/bit_serial_tx_if.sv
// Parallel-word handshake plus serial line outputs for bit_serial_tx.
interface bit_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_a;
  logic              tx_b;
  logic              frame_done;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx_a,
    input  tx_b,
    input  frame_done
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx_a,
    output tx_b,
    output frame_done
  );
endinterface

// File: rtl/bit_serial_tx.sv
// Frame-based bit-serial transmitter: start bit, data LSB-first, optional
// even parity, stop bit; each bit held for CLKS_PER_BIT clocks.
module bit_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  bit_serial_tx_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     baud, baud_d;
  logic [BW-1:0]     bitcnt, bitcnt_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic              par, par_d;
  logic              baud_last;

  logic tx_a_q, tx_b_q, done_q, ready_q;
  logic tx_a_d, tx_b_d, done_d, ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx_a_q  <= 1'b1;
      tx_b_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bitcnt  <= bitcnt_d;
      shreg   <= shreg_d;
      par     <= par_d;
      tx_a_q  <= tx_a_d;
      tx_b_q  <= tx_b_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bitcnt_d  = bitcnt;
    shreg_d   = shreg;
    par_d     = par;
    baud_last = (baud == BAUD_LAST);

    if (state != IDLE) begin
      baud_d = baud_last ? '0 : baud + CW'(1);
    end

    case (state)
      IDLE: begin
        if (bus.tx_valid) begin
          state_d  = START;
          shreg_d  = bus.tx_data;
          par_d    = ^bus.tx_data;
          baud_d   = '0;
          bitcnt_d = '0;
        end
      end
      START: begin
        if (baud_last) state_d = DATA;
      end
      DATA: begin
        if (baud_last) begin
          shreg_d = shreg >> 1;
          if (bitcnt == BIT_LAST) begin
            bitcnt_d = '0;
            state_d  = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bitcnt_d = bitcnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (baud_last) state_d = STOP;
      end
      STOP: begin
        if (baud_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line
  // up with the state they describe, keeping every output flop-driven.
  always_comb begin
    tx_a_d  = 1'b1;
    tx_b_d  = 1'b1;
    done_d  = 1'b0;
    ready_d = 1'b0;
    case (state_d)
      IDLE: begin
        tx_b_d  = 1'b0;
        ready_d = 1'b1;
        done_d  = (state == STOP);
      end
      START:   tx_a_d = 1'b0;
      DATA:    tx_a_d = shreg_d[0];
      PARITY:  tx_a_d = par_d;
      default: tx_a_d = 1'b1;
    endcase
  end

  assign bus.tx_a       = tx_a_q;
  assign bus.tx_b       = tx_b_q;
  assign bus.frame_done = done_q;
  assign bus.tx_ready   = ready_q;

endmodule

// File: tb/tb_bit_serial_tx.sv
// Directed scoreboard bench for bit_serial_tx: default build plus a
// no-parity, one-clock-per-bit build.
module tb_bit_serial_tx;

  typedef logic [3:0] obs_t; // {tx_a, tx_b, frame_done, tx_ready}

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bit_serial_tx_if #(.DATA_W(8)) b1 ();
  bit_serial_tx_if #(.DATA_W(8)) b2 ();

  bit_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1)
  );

  bit_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b2)
  );

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input obs_t obs, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample(input bit sel);
    if (sel) return {b2.tx_a, b2.tx_b, b2.frame_done, b2.tx_ready};
    return {b1.tx_a, b1.tx_b, b1.frame_done, b1.tx_ready};
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      b2.tx_valid = v;
      b2.tx_data  = d;
    end else begin
      b1.tx_valid = v;
      b1.tx_data  = d;
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input int cpb, input bit pen);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(^d);
    bits.push_back(1'b1);
    foreach (bits[k]) repeat (cpb) q.push_back({bits[k], 3'b100});
    q.push_back(4'b1011);
  endtask

  // Pops one expected entry per cycle; after the first sample the producer
  // switches to data_after/keep_valid, and valid drops once n_frames are done.
  task automatic drain(input bit sel, input string tag, input int n_frames,
                       input logic [7:0] data_after, input bit keep_valid,
                       input int max_pops);
    int   pops = 0;
    int   done = 0;
    obs_t e;
    while (q.size() > 0 && pops < max_pops) begin
      @(negedge clk);
      e = q.pop_front();
      check(tag, sample(sel), e);
      if (e[1]) done++;
      if (pops == 0) drive(sel, keep_valid, data_after);
      if (done >= n_frames) drive(sel, 1'b0, data_after);
      pops++;
    end
  endtask

  initial begin
    // reset held with tx_valid high on both instances
    rst_n = 1'b0;
    drive(0, 1'b1, 8'hA5);
    drive(1, 1'b1, 8'h80);
    repeat (3) begin
      @(negedge clk);
      check("reset", sample(0), 4'b1001);
      check("reset2", sample(1), 4'b1001);
    end
    rst_n = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    @(negedge clk);
    check("post_reset", sample(0), 4'b1001);

    // single 0xA5 frame, data changed right after the handshake
    drive(0, 1'b1, 8'hA5);
    push_frame(8'hA5, 4, 1'b1);
    q.push_back(4'b1001);
    drain(0, "a5", 1, 8'h00, 1'b0, 1000);

    // back-to-back 0x01 then 0xFF with valid held high
    drive(0, 1'b1, 8'h01);
    push_frame(8'h01, 4, 1'b1);
    push_frame(8'hFF, 4, 1'b1);
    q.push_back(4'b1001);
    drain(0, "b2b", 2, 8'hFF, 1'b1, 1000);

    // 0x3C offered while busy is only taken at the next idle cycle
    drive(0, 1'b1, 8'hC3);
    push_frame(8'hC3, 4, 1'b1);
    push_frame(8'h3C, 4, 1'b1);
    q.push_back(4'b1001);
    drain(0, "busy", 2, 8'h3C, 1'b1, 1000);

    // reset 20 cycles into a frame, checked before any clock edge
    drive(0, 1'b1, 8'h96);
    push_frame(8'h96, 4, 1'b1);
    drain(0, "pre_abort", 1, 8'h00, 1'b0, 20);
    q.delete();
    #2 rst_n = 1'b0;
    #1 check("async_reset", sample(0), 4'b1001);
    @(negedge clk);
    check("abort_hold", sample(0), 4'b1001);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_nodone", sample(0), 4'b1001);
    drive(0, 1'b1, 8'h5A);
    push_frame(8'h5A, 4, 1'b1);
    q.push_back(4'b1001);
    drain(0, "after_abort", 1, 8'h00, 1'b0, 1000);

    // no parity, one clock per bit
    drive(1, 1'b1, 8'h80);
    push_frame(8'h80, 1, 1'b0);
    q.push_back(4'b1001);
    drain(1, "p0c1", 1, 8'hFF, 1'b0, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
